inv_edge_meter: RTL and testbench
=================================

// Module: inv_edge_meter
// PURPOSE
//   Measurement stage directly downstream of the synchronised inverter test cell.
//   Counts rising and falling transitions of the cell's registered output over a
//   programmable window of clk cycles.
//   Reports both counts with a one-cycle done pulse, so the cell can be characterised
//   from the TinyTapeout IO without a logic analyser.
// PARAMETERS
//   CNT_W  16  width of each edge counter; counters saturate at 2**CNT_W-1
//   WIN_W  16  width of window_len; maximum window is 2**WIN_W-1 cycles
// PORTS
//   clk         in   1      system clock; all state changes on posedge
//   rst_n       in   1      reset; asynchronous assert and active-low; clears all state
//   vccd1/vssd1 inout 1     power pins; present only under USE_POWER_PINS
//   start       in   1      request a measurement; sampled only in IDLE
//   window_len  in   WIN_W  window length in cycles; sampled when start is accepted
//   y_in        in   1      cell output, already clk-synchronous (two flops upstream)
//   busy        out  1      high in ARM and MEASURE
//   done        out  1      one-cycle pulse when results become valid
//   rise_count  out  CNT_W  0->1 transitions seen in the last window
//   fall_count  out  CNT_W  1->0 transitions seen in the last window
//   overflow    out  1      either counter saturated during the last window
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, overflow = 0; both counts = 0; y_q = 0; remaining = 0.
//   FSM states: IDLE -> ARM -> MEASURE -> DONE -> IDLE.
//   IDLE, start=1 at an edge:
//     - next state ARM
//     - latch window_len into remaining
//     - clear rise_count, fall_count and overflow
//   ARM, one cycle:
//     - y_q <= y_in (baseline sample); no edge is counted
//     - remaining == 0 -> DONE; else -> MEASURE
//   MEASURE, each edge:
//     - y_in=1 and y_q=0 -> rise_count+1
//     - y_in=0 and y_q=1 -> fall_count+1
//     - y_q <= y_in; remaining <= remaining-1
//     - remaining == 1 -> DONE
//   Window: exactly window_len samples compared against the preceding sample.
//   DONE: done=1 for exactly one cycle; unconditional -> IDLE.
//   Counts and overflow: registered; stable from the done cycle until the next accepted start.
//   Saturation: a counter at all-ones holds its value; overflow <= 1 (sticky until next start).
//   start outside IDLE (ARM/MEASURE/DONE): ignored, not queued.
//   window_len changes after acceptance: no effect on the running window.
//   Latency: start accepted at edge k -> done high in the cycle after edge k+1+window_len.
//   rst_n low at any time, incl. mid-MEASURE: immediate return to reset values; no done pulse.
//   Arithmetic: unsigned; remaining never wraps below zero.
// TESTING
//   T1 y_in=0 at ARM, then toggles every cycle; window_len=10
//      -> rise=5, fall=5, overflow=0, done once
//   T2 y_in held 1; window_len=100 -> rise=0, fall=0, done 102 cycles after start edge
//   T3 window_len=0 -> done 2 cycles after start edge, counts=0, busy high for 1 cycle
//   T4 CNT_W=4; toggle every cycle; window_len=40
//      -> rise=15, fall=15, overflow=1
//   T5 start pulsed again mid-MEASURE
//      -> ignored; one done only; counts match a single window
//   T6 rst_n low mid-MEASURE
//      -> busy/done/counts/overflow all 0 asynchronously
//      -> next start after release measures normally

Source files
------------

// File: rtl/inv_edge_meter_if.sv
// inv_edge_meter_if: control, cell-sample and result signals of the edge meter
interface inv_edge_meter_if #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
);
  logic             start;
  logic [WIN_W-1:0] window_len;
  logic             y_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] rise_count;
  logic [CNT_W-1:0] fall_count;
  logic             overflow;
  modport master (output start, window_len, y_in, input busy, done, rise_count, fall_count, overflow);
  modport slave  (input start, window_len, y_in, output busy, done, rise_count, fall_count, overflow);
endinterface

// File: rtl/inv_edge_meter.sv
// inv_edge_meter: counts rising/falling transitions of the inverter cell output over a programmable window
module inv_edge_meter #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
`ifdef USE_POWER_PINS
  inout wire vccd1,
  inout wire vssd1,
`endif
  input logic            clk,
  input logic            rst_n,
  inv_edge_meter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIN_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_rise, r_fall;
  logic             r_ovf, r_y_q;
  logic             w_busy, w_done, w_rise_ev, w_fall_ev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb
    w_next = (r_state == IDLE) ? (bus.start ? ARM : IDLE) :
             (r_state == ARM)  ? ((r_remaining == '0) ? DONE : MEAS) :
             (r_state == MEAS) ? ((r_remaining == WIN_W'(1)) ? DONE : MEAS) : IDLE;
  always_comb begin
    w_busy = (r_state == ARM) || (r_state == MEAS);
    w_done = (r_state == DONE);
  end
  assign w_rise_ev = (r_state == MEAS) &&  bus.y_in && !r_y_q;
  assign w_fall_ev = (r_state == MEAS) && !bus.y_in &&  r_y_q;
  // A saturated counter holds and flags overflow instead of wrapping.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_remaining <= '0;
      r_rise      <= '0;
      r_fall      <= '0;
      r_ovf       <= 1'b0;
      r_y_q       <= 1'b0;
    end else if (r_state == IDLE) begin
      if (bus.start) begin
        r_remaining <= bus.window_len;
        r_rise      <= '0;
        r_fall      <= '0;
        r_ovf       <= 1'b0;
      end
    end else if (r_state == ARM) begin
      r_y_q <= bus.y_in;
    end else if (r_state == MEAS) begin
      r_y_q       <= bus.y_in;
      r_remaining <= (r_remaining == '0) ? '0 : r_remaining - WIN_W'(1);
      if (w_rise_ev) begin
        if (r_rise == '1) r_ovf  <= 1'b1;
        else              r_rise <= r_rise + CNT_W'(1);
      end
      if (w_fall_ev) begin
        if (r_fall == '1) r_ovf  <= 1'b1;
        else              r_fall <= r_fall + CNT_W'(1);
      end
    end
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.rise_count = r_rise;
  assign bus.fall_count = r_fall;
  assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_inv_edge_meter.sv
// tb_inv_edge_meter: directed scenarios with an expected-result queue, on a 16-bit and a 4-bit counter instance
module tb_inv_edge_meter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] window_len = '0;
  logic        y_in = 1'b0;
  int          errors = 0;
  int          checks = 0;
  typedef struct {
    string tag;
    int    rise;
    int    fall;
    int    ovf;
    int    lat;
  } exp_t;
  exp_t sb[$];
  inv_edge_meter_if #(.CNT_W(16), .WIN_W(16)) b16();
  inv_edge_meter_if #(.CNT_W(4),  .WIN_W(16)) b4();
  assign b16.start = start;
  assign b16.window_len = window_len;
  assign b16.y_in = y_in;
  assign b4.start = start;
  assign b4.window_len = window_len;
  assign b4.y_in = y_in;
  inv_edge_meter #(.CNT_W(16), .WIN_W(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  inv_edge_meter #(.CNT_W(4),  .WIN_W(16)) u4  (.clk(clk), .rst_n(rst_n), .bus(b4));
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic measure(input string tag, input int w, input bit hold, input bit restart);
    exp_t e, got_e;
    int   n = 0, busy_n = 0, extra = 0;
    bit   y, p, got = 0;
    y = hold;
    p = y;
    e.tag = tag; e.rise = 0; e.fall = 0; e.ovf = 0; e.lat = w + 1;
    for (int i = 0; i < w; i++) begin
      y = hold ? y : ~y;
      if (y && !p) e.rise++;
      if (!y && p) e.fall++;
      p = y;
    end
    sb.push_back(e);
    y_in = hold;
    window_len = 16'(w);
    start = 1'b1;
    tick();
    start = 1'b0;
    window_len = 16'd7;
    if (b16.busy) busy_n++;
    while (!got && n < w + 20) begin
      tick();
      n++;
      if (restart && n == 3) start = 1'b1;
      if (restart && n == 4) start = 1'b0;
      if (b16.done) got = 1;
      else begin
        if (b16.busy) busy_n++;
        if (!hold) y_in = ~y_in;
      end
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    got_e = sb.pop_front();
    check({got_e.tag, "_done_seen"}, int'(got), 1);
    check({got_e.tag, "_latency"}, n, got_e.lat);
    check({got_e.tag, "_busy_cycles"}, busy_n, w + 1);
    check({got_e.tag, "_rise"}, int'(b16.rise_count), got_e.rise);
    check({got_e.tag, "_fall"}, int'(b16.fall_count), got_e.fall);
    check({got_e.tag, "_ovf"}, int'(b16.overflow), got_e.ovf);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (b16.done || b16.busy) extra++;
    end
    check({got_e.tag, "_single_done"}, extra, 0);
    check({got_e.tag, "_rise_stable"}, int'(b16.rise_count), got_e.rise);
  endtask

  initial begin
    #12;
    check("rst_busy", int'(b16.busy), 0);
    check("rst_done", int'(b16.done), 0);
    check("rst_rise", int'(b16.rise_count), 0);
    check("rst_fall", int'(b16.fall_count), 0);
    check("rst_ovf", int'(b16.overflow), 0);
    tick();
    rst_n = 1'b1;
    tick();
    measure("t1_toggle10", 10, 1'b0, 1'b0);
    measure("t2_hold100", 100, 1'b1, 1'b0);
    measure("t3_zero", 0, 1'b0, 1'b0);
    measure("t4_toggle40", 40, 1'b0, 1'b0);
    check("t4_cnt4_rise", int'(b4.rise_count), 15);
    check("t4_cnt4_fall", int'(b4.fall_count), 15);
    check("t4_cnt4_ovf", int'(b4.overflow), 1);
    measure("t5_restart", 20, 1'b0, 1'b1);
    check("t5_cnt4_ovf", int'(b4.overflow), 0);
    window_len = 16'd60;
    y_in = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 41; i++) begin
      tick();
      y_in = ~y_in;
    end
    check("t6_busy_before", int'(b16.busy), 1);
    check("t6_cnt4_ovf_before", int'(b4.overflow), 1);
    rst_n = 1'b0;
    #1;
    check("t6_busy", int'(b16.busy), 0);
    check("t6_done", int'(b16.done), 0);
    check("t6_rise", int'(b16.rise_count), 0);
    check("t6_fall", int'(b16.fall_count), 0);
    check("t6_cnt4_ovf", int'(b4.overflow), 0);
    tick();
    tick();
    check("t6_done_in_reset", int'(b16.done), 0);
    rst_n = 1'b1;
    tick();
    measure("t6_after", 12, 1'b0, 1'b0);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
